seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one seven-segment decoder (4-bit code in, 7 segments out; codes 0-9 are digits, codes above 9 light no segments) across NUM_DIGITS common-cathode digits.
- Sequences digit enables and presents the current digit's 4-bit code to the decoder.
- Inserts a blanking guard before each digit slot to suppress ghosting.
- Double-buffers display data so updates apply only at frame boundaries (no tearing).
- Sits between the counter/datapath logic and the decoder plus pad drivers.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8).
REFRESH_DIV, 1000, clock cycles per digit slot (must be > BLANK_CYCLES).
BLANK_CYCLES, 2, cycles at the start of each slot with all digit enables off (0 allowed = no guard).

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, asynchronous assert, active-low.
enable  in  1  scan enable; 0 = idle, all digits off.
digits_in  in  4*NUM_DIGITS  packed codes; digit 0 (least significant) = bits [3:0].
load  in  1  strobe; capture digits_in into pending buffer.
lz_blank  in  1  leading-zero suppression enable.
digit_code  out  4  code to decoder for the current slot.
digit_sel  out  NUM_DIGITS  one-hot active-high digit enable; all-zero during guard/idle.
frame_done  out  1  one-cycle pulse on the last cycle of slot NUM_DIGITS-1.
update_pending  out  1  pending buffer holds data not yet displayed.

Behaviour:
- Reset (async, rst_n=0) clears the following to 0: digit_sel, frame_done, update_pending, digit_code, active buffer, pending buffer, slot counter, digit index.
- Clock and reset: one clock domain. Reset is asynchronous and active-low, on rst_n. Reset deassertion is synchronous to clk.
- All outputs are registered. digit_sel and digit_code update on the same edge.
- FSM states:
  - IDLE: entered when enable=0. Counters held at 0, digit_sel=0, digit_code=4'hF.
  - GUARD: slot cycles 0..BLANK_CYCLES-1. digit_sel=0, digit_code=4'hF.
  - SHOW: slot cycles BLANK_CYCLES..REFRESH_DIV-1. digit_sel=one-hot(idx), digit_code=active[idx] or 4'hF if suppressed.
- Transitions:
  - IDLE->GUARD (or SHOW if BLANK_CYCLES=0) on the first cycle with enable=1; the scan starts at idx=0, slot cycle 0.
  - At slot cycle REFRESH_DIV-1 the slot cycle wraps to 0 and idx increments, wrapping NUM_DIGITS-1 -> 0.
  - enable=0 in any state -> IDLE on the next edge. The scan restarts from idx 0 when re-enabled.
- Slot cycle counter width: clog2(REFRESH_DIV).
- Buffering:
  - load=1 captures digits_in into pending and sets update_pending. Repeated loads overwrite; latest wins.
  - At the frame boundary (the frame_done cycle), if update_pending=1: pending->active and update_pending clears on that edge. Slot 0 of the next frame shows the new data.
  - load in the same cycle as frame_done: the new digits_in go directly to active and update_pending stays 0.
  - In IDLE, a pending update transfers to active immediately on the next edge.
- Leading-zero suppression (lz_blank=1): scanning from idx NUM_DIGITS-1 downward, every active digit equal to 0 is shown as 4'hF until the first nonzero digit. Digit 0 is never suppressed. Evaluated on the active buffer.
- Codes 10..15 pass through unchanged; the decoder blanks them.
- frame_done asserts only while scanning (not in IDLE).

Decomposition:
- Shared package seg7_pkg:
  - DIGIT_W=4.
  - BLANK_CODE=4'hF.
  - Scan state enum {IDLE, GUARD, SHOW}.
- One natural sub-module, seg7_slot_timer: slot-cycle counter plus digit index with wrap. Outputs slot_cycle, idx, slot_last and frame_last.
- The top module holds the FSM, the buffers and the leading-zero logic.
- The seg7 decoder is instantiated by the parent, not inside this block.

Test Plan:
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset, then enable=1, load digits 4,3,2,1 (digit 0 = 1) -> after the first boundary, each slot shows 2 cycles of digit_sel=0/code F, then 6 cycles of digit_sel=0001/code 1, then 0010/code 2, 0100/code 3, 1000/code 4; frame_done pulses every 32 cycles.
2. load new value mid-frame (slot 1) -> update_pending=1; the old digits finish the frame; new digits appear from slot 0 of the next frame; update_pending drops on the frame_done edge.
3. lz_blank=1, digits 0,0,5,0 (digit 3 = 0) -> digits 3,2 show code F; digit 1 shows 5; digit 0 shows 0. Digits 0,0,0,0 -> only digit 0 shows 0.
4. enable drops during SHOW of slot 2 -> next edge digit_sel=0, code F; re-enable restarts at slot 0 in GUARD.
5. rst_n asserted mid-slot, asynchronously between edges -> digit_sel, frame_done and update_pending go to 0 immediately without a clock edge; active buffer clears (code 0 is shown after re-enable).
6. BLANK_CYCLES=0 build, and load coincident with frame_done -> no guard cycles; new data in slot 0 of the next frame; update_pending never sets.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   DIGIT_W       - width of one digit code presented to the decoder
//   BLANK_CODE    - code the decoder renders with all segments off
//   scan_state_e  - scan FSM states (IDLE must encode as 0; it is the reset state)
//   code_or_blank - substitutes BLANK_CODE for a suppressed digit
package seg7_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  function automatic logic [DIGIT_W-1:0] code_or_blank(input logic                blank,
                                                       input logic [DIGIT_W-1:0] code);
    return blank ? BLANK_CODE : code;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Bundle between the counter/datapath logic (master) and the scan controller (slave).
//   enable         - scan enable; 0 parks the controller with every digit off
//   digits_in      - packed digit codes, digit 0 in the least significant nibble
//   load           - strobe capturing digits_in into the pending buffer
//   lz_blank       - leading-zero suppression enable
//   digit_code     - code for the decoder during the current slot
//   digit_sel      - one-hot active-high digit enable, all zero while blanked
//   frame_done     - one-cycle pulse on the last cycle of the last digit slot
//   update_pending - pending buffer holds data not yet on the display
interface seg7_scan_ctrl_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                          enable;
  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in;
  logic                          load;
  logic                          lz_blank;
  logic [DIGIT_W-1:0]            digit_code;
  logic [NUM_DIGITS-1:0]         digit_sel;
  logic                          frame_done;
  logic                          update_pending;

  modport master (
    output enable,
    output digits_in,
    output load,
    output lz_blank,
    input  digit_code,
    input  digit_sel,
    input  frame_done,
    input  update_pending
  );

  modport slave (
    input  enable,
    input  digits_in,
    input  load,
    input  lz_blank,
    output digit_code,
    output digit_sel,
    output frame_done,
    output update_pending
  );

endinterface

// File: rtl/seg7_slot_timer.sv
// Slot-cycle counter and digit index for the scan controller.
// The outputs describe the cycle that begins at the next clock edge, so the parent can
// register its display outputs in step with the counters.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - restart the scan: the next cycle is slot cycle 0 of digit 0
//   slot_cycle  - slot cycle of the upcoming cycle
//   idx         - digit index of the upcoming cycle
//   slot_last   - upcoming cycle is the last cycle of its slot
//   frame_last  - upcoming cycle is the last cycle of the last digit's slot
module seg7_slot_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  output logic [$clog2(REFRESH_DIV)-1:0] slot_cycle,
  output logic [$clog2(NUM_DIGITS)-1:0]  idx,
  output logic                           slot_last,
  output logic                           frame_last
);

  localparam int SlotW = $clog2(REFRESH_DIV);
  localparam int IdxW  = $clog2(NUM_DIGITS);

  localparam logic [SlotW-1:0] SlotMax = SlotW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0]  IdxMax  = IdxW'(NUM_DIGITS - 1);

  logic [SlotW-1:0] slot_q, slot_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  always_comb begin
    slot_d = slot_q;
    idx_d  = idx_q;
    if (clear) begin
      slot_d = '0;
      idx_d  = '0;
    end else if (slot_q == SlotMax) begin
      slot_d = '0;
      idx_d  = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end else begin
      slot_d = slot_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      idx_q  <= '0;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
    end
  end

  assign slot_cycle = slot_d;
  assign idx        = idx_d;
  assign slot_last  = (slot_d == SlotMax);
  assign frame_last = slot_last && (idx_d == IdxMax);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller sharing one seven-segment decoder across NUM_DIGITS
// common-cathode digits. Each digit slot lasts REFRESH_DIV cycles; the first BLANK_CYCLES
// of a slot keep every digit off to suppress ghosting. Display data is double-buffered so
// new values only reach the digits at frame boundaries.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - slave side of seg7_scan_ctrl_if (enable, digits_in, load, lz_blank in;
//                digit_code, digit_sel, frame_done, update_pending out, all registered)
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int SlotW = $clog2(REFRESH_DIV);
  localparam int IdxW  = $clog2(NUM_DIGITS);
  localparam int BufW  = DIGIT_W * NUM_DIGITS;

  localparam logic [1:0] StIdle  = IDLE;
  localparam logic [1:0] StGuard = GUARD;
  localparam logic [1:0] StShow  = SHOW;

  logic [1:0]            state_q, state_d;
  logic [BufW-1:0]       active_q, active_d;
  logic [BufW-1:0]       pending_q, pending_d;
  logic                  pend_q, pend_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [DIGIT_W-1:0]    code_q, code_d;
  logic                  fd_q, fd_d;

  logic                  timer_clear;
  logic [SlotW-1:0]      slot_nxt;
  logic [IdxW-1:0]       idx_nxt;
  logic                  unused_slot_last;
  logic                  frame_last_nxt;

  logic [NUM_DIGITS-1:0] suppress;
  logic                  seen_nonzero;
  logic [DIGIT_W-1:0]    shown_code;

  // Counters stay parked at zero while idle, so the first enabled cycle starts digit 0.
  assign timer_clear = !bus.enable || (state_q == StIdle);

  seg7_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_slot_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (timer_clear),
    .slot_cycle (slot_nxt),
    .idx        (idx_nxt),
    .slot_last  (unused_slot_last),
    .frame_last (frame_last_nxt)
  );

  // Buffers. fd_q marks the last cycle of a frame: anything taking effect on the edge
  // that ends it is visible from slot 0 of the next frame. A load on that very cycle
  // skips the pending stage.
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    if (bus.load) begin
      if (fd_q) begin
        active_d = bus.digits_in;
        pend_d   = 1'b0;
      end else begin
        pending_d = bus.digits_in;
        pend_d    = 1'b1;
      end
    end else if (pend_q && (fd_q || (state_q == StIdle))) begin
      active_d = pending_q;
      pend_d   = 1'b0;
    end
  end

  // Leading-zero suppression, evaluated on the buffer the next cycle will display.
  // Digit 0 is never suppressed so a zero value still shows a single 0.
  always_comb begin
    seen_nonzero = 1'b0;
    suppress     = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (active_d[i*DIGIT_W +: DIGIT_W] != '0) begin
        seen_nonzero = 1'b1;
      end
      suppress[i] = bus.lz_blank && !seen_nonzero;
    end
  end

  assign shown_code = code_or_blank(suppress[idx_nxt],
                                    active_d[int'(idx_nxt)*DIGIT_W +: DIGIT_W]);

  // Outputs are computed for the upcoming cycle and registered alongside the counters.
  always_comb begin
    if (!bus.enable) begin
      state_d = StIdle;
    end else if (int'(slot_nxt) < BLANK_CYCLES) begin
      state_d = StGuard;
    end else begin
      state_d = StShow;
    end

    sel_d  = '0;
    code_d = BLANK_CODE;
    if (state_d == StShow) begin
      sel_d[idx_nxt] = 1'b1;
      code_d         = shown_code;
    end

    fd_d = bus.enable && frame_last_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      active_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
      sel_q     <= '0;
      code_q    <= '0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      sel_q     <= sel_d;
      code_q    <= code_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.digit_sel      = sel_q;
  assign bus.digit_code     = code_q;
  assign bus.frame_done     = fd_q;
  assign bus.update_pending = pend_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: NUM_DIGITS=4, REFRESH_DIV=8, a BLANK_CYCLES=2 build
// (dut) and a BLANK_CYCLES=0 build (dut0). Outputs are sampled on the falling edge.
module tb_seg7_scan_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  seg7_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();
  seg7_scan_ctrl_if #(.NUM_DIGITS(4)) bus0 ();

  seg7_scan_ctrl #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  seg7_scan_ctrl #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (0)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.enable = 1'b0;  bus.digits_in = '0;  bus.load = 1'b0;  bus.lz_blank = 1'b0;
    bus0.enable = 1'b0; bus0.digits_in = '0; bus0.load = 1'b0; bus0.lz_blank = 1'b0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    tests++; if (bus.digit_sel !== 4'b0) begin
      fails++; $display("FAIL reset_sel: got %b expected 0000", bus.digit_sel); end
    tests++; if (bus.digit_code !== 4'h0) begin
      fails++; $display("FAIL reset_code: got %h expected 0", bus.digit_code); end
    tests++; if (bus.frame_done !== 1'b0) begin
      fails++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
    tests++; if (bus.update_pending !== 1'b0) begin
      fails++; $display("FAIL reset_pending: got %b expected 0", bus.update_pending); end
    tests++; if (bus0.digit_sel !== 4'b0) begin
      fails++; $display("FAIL reset_sel0: got %b expected 0000", bus0.digit_sel); end
    rst_n = 1'b1;
    tick();
    tests++; if ({bus.digit_sel, bus.digit_code} !== {4'b0, 4'hF}) begin
      fails++; $display("FAIL idle_out: got %b/%h expected 0000/f", bus.digit_sel,
                        bus.digit_code); end
  endtask

  // Load 4321 while idle, then check two full frames cycle by cycle.
  task automatic test_scan();
    logic [3:0] es, ec;
    logic       ef;
    bus.digits_in = 16'h4321;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tests++; if (bus.update_pending !== 1'b1) begin
      fails++; $display("FAIL scan_pending_set: got %b expected 1", bus.update_pending); end
    tick();
    tests++; if (bus.update_pending !== 1'b0) begin
      fails++; $display("FAIL scan_idle_xfer: got %b expected 0", bus.update_pending); end
    bus.enable = 1'b1;
    tick();
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 32; p++) begin
        es = (p % 8 < 2) ? 4'b0 : 4'(4'b0001 << (p / 8));
        ec = (p % 8 < 2) ? 4'hF : 4'(p / 8 + 1);
        ef = (p == 31);
        tests++; if ({bus.digit_sel, bus.digit_code, bus.frame_done} !== {es, ec, ef}) begin
          fails++; $display("FAIL scan f%0d p%0d: got %b/%h/%b expected %b/%h/%b", f, p,
                            bus.digit_sel, bus.digit_code, bus.frame_done, es, ec, ef); end
        tick();
      end
    end
  endtask

  // Load 8765 during slot 1 of a frame: old digits finish, new ones from next frame.
  task automatic test_midframe_load();
    logic [3:0] es, ec;
    logic       ef, ep;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 32; p++) begin
        es = (p % 8 < 2) ? 4'b0 : 4'(4'b0001 << (p / 8));
        ec = (p % 8 < 2) ? 4'hF : 4'(p / 8 + ((f == 0) ? 1 : 5));
        ef = (p == 31);
        ep = (f == 0) && (p > 9);
        tests++; if ({bus.digit_sel, bus.digit_code, bus.frame_done, bus.update_pending}
                     !== {es, ec, ef, ep}) begin
          fails++; $display("FAIL midload f%0d p%0d: got %b/%h/%b/%b expected %b/%h/%b/%b",
                            f, p, bus.digit_sel, bus.digit_code, bus.frame_done,
                            bus.update_pending, es, ec, ef, ep); end
        if (f == 0 && p == 9) begin
          bus.digits_in = 16'h8765;
          bus.load = 1'b1;
        end
        tick();
        bus.load = 1'b0;
      end
    end
  endtask

  // Leading-zero suppression on 0050, 0000 and 00A0.
  task automatic test_lz();
    logic [15:0] exp_tab [3];
    logic [15:0] ld_tab [3];
    logic [15:0] ev;
    logic [3:0]  es, ec;
    exp_tab = '{16'hFF50, 16'hFFF0, 16'hFFA0};
    ld_tab  = '{16'h0000, 16'h00A0, 16'h00A0};
    bus.lz_blank  = 1'b1;
    bus.digits_in = 16'h0050;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    for (int f = 0; f < 3; f++) begin
      ev = exp_tab[f];
      for (int p = 0; p < 32; p++) begin
        es = (p % 8 < 2) ? 4'b0 : 4'(4'b0001 << (p / 8));
        ec = (p % 8 < 2) ? 4'hF : ev[(p / 8) * 4 +: 4];
        tests++; if ({bus.digit_sel, bus.digit_code} !== {es, ec}) begin
          fails++; $display("FAIL lz f%0d p%0d: got %b/%h expected %b/%h", f, p,
                            bus.digit_sel, bus.digit_code, es, ec); end
        if (p == 0 && f < 2) begin
          bus.digits_in = ld_tab[f];
          bus.load = 1'b1;
        end
        tick();
        bus.load = 1'b0;
      end
    end
    bus.lz_blank = 1'b0;
  endtask

  // Drop enable in slot 2, load while idle, re-enable and confirm restart from digit 0.
  task automatic test_enable_drop();
    for (int i = 0; i < 19; i++) tick();
    tests++; if ({bus.digit_sel, bus.digit_code} !== {4'b0100, 4'h0}) begin
      fails++; $display("FAIL drop_pre: got %b/%h expected 0100/0", bus.digit_sel,
                        bus.digit_code); end
    bus.enable = 1'b0;
    tick();
    tests++; if ({bus.digit_sel, bus.digit_code, bus.frame_done} !== {4'b0, 4'hF, 1'b0}) begin
      fails++; $display("FAIL drop_idle: got %b/%h/%b expected 0000/f/0", bus.digit_sel,
                        bus.digit_code, bus.frame_done); end
    bus.digits_in = 16'h0009;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tests++; if ({bus.update_pending, bus.digit_sel} !== {1'b1, 4'b0}) begin
      fails++; $display("FAIL drop_load: got %b/%b expected 1/0000", bus.update_pending,
                        bus.digit_sel); end
    tick();
    tests++; if (bus.update_pending !== 1'b0) begin
      fails++; $display("FAIL drop_xfer: got %b expected 0", bus.update_pending); end
    bus.enable = 1'b1;
    tick();
    tests++; if ({bus.digit_sel, bus.digit_code} !== {4'b0, 4'hF}) begin
      fails++; $display("FAIL reen_guard: got %b/%h expected 0000/f", bus.digit_sel,
                        bus.digit_code); end
    tick();
    tick();
    tests++; if ({bus.digit_sel, bus.digit_code} !== {4'b0001, 4'h9}) begin
      fails++; $display("FAIL reen_show: got %b/%h expected 0001/9", bus.digit_sel,
                        bus.digit_code); end
  endtask

  // Asynchronous reset between edges while showing digit 0 with an update pending.
  task automatic test_async_reset();
    bus.digits_in = 16'h1111;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tests++; if ({bus.update_pending, bus.digit_sel} !== {1'b1, 4'b0001}) begin
      fails++; $display("FAIL areset_pre: got %b/%b expected 1/0001", bus.update_pending,
                        bus.digit_sel); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({bus.digit_sel, bus.frame_done, bus.update_pending, bus.digit_code}
                 !== {4'b0, 1'b0, 1'b0, 4'h0}) begin
      fails++; $display("FAIL areset_now: got %b/%b/%b/%h expected 0000/0/0/0",
                        bus.digit_sel, bus.frame_done, bus.update_pending, bus.digit_code); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++; if ({bus.digit_sel, bus.digit_code} !== {4'b0, 4'hF}) begin
      fails++; $display("FAIL areset_guard: got %b/%h expected 0000/f", bus.digit_sel,
                        bus.digit_code); end
    tick();
    tick();
    tests++; if ({bus.digit_sel, bus.digit_code} !== {4'b0001, 4'h0}) begin
      fails++; $display("FAIL areset_cleared: got %b/%h expected 0001/0", bus.digit_sel,
                        bus.digit_code); end
    bus.enable = 1'b0;
    tick();
  endtask

  // No-guard build, with a load landing on the frame_done cycle.
  task automatic test_no_guard();
    logic [3:0] es, ec;
    logic       ef;
    bus0.digits_in = 16'h4321;
    bus0.load = 1'b1;
    tick();
    bus0.load = 1'b0;
    tick();
    bus0.enable = 1'b1;
    tick();
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 32; p++) begin
        es = 4'(4'b0001 << (p / 8));
        ec = 4'(p / 8 + ((f == 0) ? 1 : 5));
        ef = (p == 31);
        tests++; if ({bus0.digit_sel, bus0.digit_code, bus0.frame_done, bus0.update_pending}
                     !== {es, ec, ef, 1'b0}) begin
          fails++; $display("FAIL noguard f%0d p%0d: got %b/%h/%b/%b expected %b/%h/%b/0",
                            f, p, bus0.digit_sel, bus0.digit_code, bus0.frame_done,
                            bus0.update_pending, es, ec, ef); end
        if (f == 0 && p == 31) begin
          bus0.digits_in = 16'h8765;
          bus0.load = 1'b1;
        end
        tick();
        bus0.load = 1'b0;
      end
    end
    bus0.enable = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_scan();
    test_midframe_load();
    test_lz();
    test_enable_drop();
    test_async_reset();
    test_no_guard();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
